// File: rtl/rsa_pkg.sv
// Shared types and constants for the modular-exponentiation controller.
package rsa_pkg;

  localparam int unsigned RSA_DATA_WIDTH = 8;
  localparam logic [RSA_DATA_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_REQ  = 4'd1,
    ST_INIT_WAIT = 4'd2,
    ST_SQ_REQ    = 4'd3,
    ST_SQ_WAIT   = 4'd4,
    ST_MUL_REQ   = 4'd5,
    ST_MUL_WAIT  = 4'd6,
    ST_NEXT      = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERR       = 4'd9
  } state_t;

  // Operand select for the product register feeding the core dividend.
  typedef enum logic [1:0] {
    MUL_ONE = 2'd0,
    MUL_SQ  = 2'd1,
    MUL_AM  = 2'd2
  } mul_op_t;

endpackage

// File: rtl/rsa_mul_reg.sv
// Registered product: loads 1, acc*acc or acc*m; its output is the core dividend.
module rsa_mul_reg
  import rsa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RSA_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  mul_op_t                 op,
  input  logic [DATA_WIDTH-1:0]   acc,
  input  logic [DATA_WIDTH-1:0]   m,
  output logic [2*DATA_WIDTH-1:0] prod
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
    end else if (en) begin
      case (op)
        MUL_ONE: prod <= PW'(1);
        MUL_SQ:  prod <= PW'(acc) * PW'(acc);
        default: prod <= PW'(acc) * PW'(m);
      endcase
    end
  end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modular-reduction core.
// Optional RSA_MODEXP_SKIP_LZ_EN: begin at the exponent's leading one and skip its redundant square.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RSA_DATA_WIDTH
) (
  input  logic                    exp_clk,
  input  logic                    exp_rst,
  input  logic                    exp_start,
  input  logic [DATA_WIDTH-1:0]   exp_m,
  input  logic [DATA_WIDTH-1:0]   exp_e,
  input  logic [DATA_WIDTH-1:0]   exp_n,
  output logic                    exp_busy,
  output logic                    exp_done,
  output logic                    exp_err,
  output logic [DATA_WIDTH-1:0]   exp_c,
  output logic                    core_start,
  output logic [2*DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0]   core_b,
  input  logic                    core_done,
  input  logic                    core_err,
  input  logic [DATA_WIDTH-1:0]   core_c
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   m_q, m_d, e_q, e_d, n_q, n_d, acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    busy_d, done_d, err_d, start_d;
  logic [DATA_WIDTH-1:0]   c_d;
  logic                    mul_en;
  mul_op_t                 mul_op;

  assign core_b = n_q;

`ifdef RSA_MODEXP_SKIP_LZ_EN
  logic [IDX_W-1:0] msb_idx;

  // Position of the highest set exponent bit (0 when e is zero).
  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (e_q[i]) msb_idx = IDX_W'(i);
    end
  end
`endif

  rsa_mul_reg #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk  (exp_clk),
    .rst  (exp_rst),
    .en   (mul_en),
    .op   (mul_op),
    .acc  (acc_q),
    .m    (m_q),
    .prod (core_a)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    busy_d  = exp_busy;
    done_d  = 1'b0;
    err_d   = exp_err;
    c_d     = exp_c;
    start_d = 1'b0;
    mul_en  = 1'b0;
    mul_op  = MUL_SQ;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the completion pulse waits one more cycle.
        if (exp_start && !exp_done) begin
          m_d     = exp_m;
          e_d     = exp_e;
          n_d     = exp_n;
          acc_d   = '0;
          idx_d   = IDX_W'(DATA_WIDTH - 1);
          busy_d  = 1'b1;
          state_d = ST_INIT_REQ;
        end
      end
      ST_INIT_REQ: begin
        mul_en  = 1'b1;
        mul_op  = MUL_ONE;
        start_d = 1'b1;
        state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (core_done) begin
          if (core_err) begin
            state_d = ST_ERR;
          end else begin
            acc_d = core_c;
`ifdef RSA_MODEXP_SKIP_LZ_EN
            if (e_q == '0) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = msb_idx;
              state_d = ST_MUL_REQ;
            end
`else
            state_d = ST_SQ_REQ;
`endif
          end
        end
      end
      ST_SQ_REQ: begin
        mul_en  = 1'b1;
        mul_op  = MUL_SQ;
        start_d = 1'b1;
        state_d = ST_SQ_WAIT;
      end
      ST_SQ_WAIT: begin
        if (core_done) begin
          acc_d   = core_c;
          state_d = e_q[idx_q] ? ST_MUL_REQ : ST_NEXT;
        end
      end
      ST_MUL_REQ: begin
        mul_en  = 1'b1;
        mul_op  = MUL_AM;
        start_d = 1'b1;
        state_d = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (core_done) begin
          acc_d   = core_c;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SQ_REQ;
        end
      end
      ST_DONE: begin
        c_d     = acc_q;
        done_d  = 1'b1;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        c_d     = {DATA_WIDTH{ALL_ONES[0]}};
        done_d  = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge exp_clk or posedge exp_rst) begin
    if (exp_rst) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      e_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      idx_q      <= IDX_W'(DATA_WIDTH - 1);
      exp_busy   <= 1'b0;
      exp_done   <= 1'b0;
      exp_err    <= 1'b0;
      exp_c      <= '0;
      core_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      e_q        <= e_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      exp_busy   <= busy_d;
      exp_done   <= done_d;
      exp_err    <= err_d;
      exp_c      <= c_d;
      core_start <= start_d;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl with a behavioural reduction core and modpow reference.
module tb_rsa_modexp_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned L  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exp_start = 1'b0;
  logic [DW-1:0] exp_m = '0, exp_e = '0, exp_n = '0;
  logic          exp_busy, exp_done, exp_err;
  logic [DW-1:0] exp_c;
  logic          core_start;
  logic [2*DW-1:0] core_a;
  logic [DW-1:0] core_b;
  logic          core_done = 1'b0, core_err = 1'b0;
  logic [DW-1:0] core_c = '0;

  typedef struct {
    logic [DW-1:0] c;
    logic          err;
    int unsigned   lat;
    int unsigned   acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          dones = 0;
  int          expected_dones = 0;
  int unsigned cyc = 0;

  rsa_modexp_ctrl #(.DATA_WIDTH(DW)) dut (
    .exp_clk   (clk),
    .exp_rst   (rst),
    .exp_start (exp_start),
    .exp_m     (exp_m),
    .exp_e     (exp_e),
    .exp_n     (exp_n),
    .exp_busy  (exp_busy),
    .exp_done  (exp_done),
    .exp_err   (exp_err),
    .exp_c     (exp_c),
    .core_start(core_start),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_done (core_done),
    .core_err  (core_err),
    .core_c    (core_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: repeated multiplication, no bit scanning.
  function automatic logic [DW-1:0] ref_pow(input int unsigned m, input int unsigned e,
                                            input int unsigned n);
    int unsigned r;
    if (n == 0) return 8'hFF;
    r = 1 % n;
    for (int unsigned i = 0; i < e; i++) r = (r * m) % n;
    return DW'(r);
  endfunction

  function automatic int unsigned ref_lat(input logic [DW-1:0] e, input logic [DW-1:0] n);
    int unsigned pop;
    int unsigned top;
    pop = $countones(e);
    top = 0;
    for (int unsigned i = 0; i < DW; i++) if (e[i]) top = i;
    if (n == 0) return 2 + (L + 2);
`ifdef RSA_MODEXP_SKIP_LZ_EN
    if (e == 0) return 2 + (L + 2);
    return 2 + (L + 2) * (1 + top + pop) + top + 1;
`else
    return 2 + (L + 2) * (1 + DW + pop) + DW;
`endif
  endfunction

  // Behavioural reduction core: done L cycles after start, error on zero divisor.
  int unsigned     core_cnt = 0;
  logic [2*DW-1:0] lat_a = '0;
  logic [DW-1:0]   lat_b = '0;
  always @(negedge clk) begin
    if (rst) begin
      core_cnt  = 0;
      core_done = 1'b0;
      core_err  = 1'b0;
    end else if (core_start) begin
      chk("core_start_overlap", longint'(core_cnt == 0 && !core_done), 1);
      lat_a     = core_a;
      lat_b     = core_b;
      core_cnt  = L;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (core_cnt > 0) begin
        chk("core_a_stable", longint'(core_a), longint'(lat_a));
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_err  = (lat_b == 0);
          core_c    = (lat_b == 0) ? '0 : DW'(lat_a % {8'h00, lat_b});
        end
      end
    end
  end

  // Monitor: every completion pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (!rst && exp_done) begin
      dones++;
      if (exp_q.size() == 0) begin
        chk("done_without_request", longint'(exp_q.size()), 1);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("exp_c", longint'(exp_c), longint'(x.c));
        chk("exp_err", longint'(exp_err), longint'(x.err));
        chk("latency", longint'(cyc - x.acc_cyc), longint'(x.lat));
      end
    end
  end

  // Hold start until accepted; returns the number of cycles start was offered.
  task automatic issue(input logic [DW-1:0] m, input logic [DW-1:0] e,
                       input logic [DW-1:0] n, output int tries);
    int unsigned c0;
    int guard;
    exp_t x;
    guard = 0;
    while (exp_busy && guard < 1000) begin @(negedge clk); guard++; end
    tries = 0;
    exp_m = m; exp_e = e; exp_n = n; exp_start = 1'b1;
    do begin
      c0 = cyc;
      tries++;
      @(negedge clk);
    end while (!exp_busy && tries < 10);
    chk("start_accepted", longint'(exp_busy), 1);
    x.c = ref_pow(m, e, n);
    x.err = (n == 0);
    x.lat = ref_lat(e, n);
    x.acc_cyc = c0;
    exp_q.push_back(x);
    expected_dones++;
    exp_start = 1'b0;
    exp_m = DW'($urandom); exp_e = DW'($urandom); exp_n = DW'($urandom);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!exp_done && guard < 2000) begin @(negedge clk); guard++; end
    chk("done_seen", longint'(exp_done), 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin @(negedge clk); guard++; end
    chk("queue_drained", longint'(exp_q.size()), 0);
  endtask

  initial begin
    int tries;
    int guard;
    int starts;
    logic [DW-1:0] rn;

    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(exp_busy), 0);
    chk("rst_done", longint'(exp_done), 0);
    chk("rst_err", longint'(exp_err), 0);
    chk("rst_c", longint'(exp_c), 0);
    chk("rst_core_start", longint'(core_start), 0);
    chk("rst_core_a", longint'(core_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases; the second one is offered during the first one's done pulse.
    issue(8'd5, 8'd3, 8'd13, tries);
    chk("tries_idle", tries, 1);
    wait_done();
    issue(8'd7, 8'd0, 8'd10, tries);
    chk("tries_on_done_cycle", tries, 2);
    issue(8'd2, 8'd255, 8'd251, tries);
    issue(8'd9, 8'd5, 8'd1, tries);
    issue(8'd200, 8'd77, 8'd0, tries);
    issue(8'd255, 8'd255, 8'd255, tries);
    issue(8'd255, 8'd128, 8'd2, tries);

    // Operand flood while busy must not disturb the accepted request.
    issue(8'd6, 8'd11, 8'd17, tries);
    guard = 0;
    while (exp_busy && guard < 500) begin
      exp_start = 1'($urandom);
      exp_m = DW'($urandom); exp_e = DW'($urandom); exp_n = DW'($urandom);
      @(negedge clk);
      guard++;
    end
    exp_start = 1'b0;
    chk("flood_done_pulse", longint'(exp_done), 1);

    for (int k = 0; k < 24; k++) begin
      rn = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 255));
      issue(DW'($urandom), DW'($urandom), rn, tries);
    end
    drain();

    // Asynchronous reset while the first square is outstanding.
    issue(8'd11, 8'd200, 8'd97, tries);
    starts = 0;
    guard = 0;
    while (starts < 2 && guard < 200) begin
      @(negedge clk);
      if (core_start) starts++;
      guard++;
    end
    chk("reached_sq_wait", starts, 2);
    #1 rst = 1'b1;
    #1;
    chk("async_busy_clear", longint'(exp_busy), 0);
    chk("async_core_start_clear", longint'(core_start), 0);
    chk("async_core_a_clear", longint'(core_a), 0);
    exp_q.delete();
    expected_dones--;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(8'd3, 8'd4, 8'd7, tries);
    drain();
    repeat (5) @(negedge clk);
    chk("done_count", dones, expected_dones);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
